// File: rtl/hazard_detection_unit_if.sv
// Pipeline-control bus between the datapath and the hazard detection unit.
// The datapath side (master) supplies decode/EX/MEM register info and
// receives the stall, bubble and flush controls plus the debug counters.
interface hazard_detection_unit_if #(
  parameter int REG_SIZE = 5,
  parameter int CNT_SIZE = 32
);
  logic                i_enable;
  logic [REG_SIZE-1:0] i_ID_rs;
  logic [REG_SIZE-1:0] i_ID_rt;
  logic                i_ID_uses_rt;
  logic                i_ID_branch;
  logic                i_ID_halt;
  logic                i_branch_taken;
  logic [REG_SIZE-1:0] i_EX_rd;
  logic                i_EX_mem_read;
  logic                i_EX_write_reg;
  logic [REG_SIZE-1:0] i_MEM_rd;
  logic                i_MEM_mem_read;
  logic                o_pc_write;
  logic                o_IF_ID_write;
  logic                o_ID_EX_bubble;
  logic                o_IF_ID_flush;
  logic                o_halted;
  logic [CNT_SIZE-1:0] o_stall_count;
  logic [CNT_SIZE-1:0] o_flush_count;

  modport master (
    output i_enable, i_ID_rs, i_ID_rt, i_ID_uses_rt, i_ID_branch, i_ID_halt,
           i_branch_taken, i_EX_rd, i_EX_mem_read, i_EX_write_reg,
           i_MEM_rd, i_MEM_mem_read,
    input  o_pc_write, o_IF_ID_write, o_ID_EX_bubble, o_IF_ID_flush,
           o_halted, o_stall_count, o_flush_count
  );

  modport slave (
    input  i_enable, i_ID_rs, i_ID_rt, i_ID_uses_rt, i_ID_branch, i_ID_halt,
           i_branch_taken, i_EX_rd, i_EX_mem_read, i_EX_write_reg,
           i_MEM_rd, i_MEM_mem_read,
    output o_pc_write, o_IF_ID_write, o_ID_EX_bubble, o_IF_ID_flush,
           o_halted, o_stall_count, o_flush_count
  );
endinterface

// File: rtl/hazard_detection_unit.sv
// Hazard detection unit: stalls IF/ID and bubbles ID/EX on load-use and
// ID-stage branch operand hazards, flushes IF/ID on taken branches/jumps,
// drains the pipeline after HALT and keeps saturating stall/flush counters.
module hazard_detection_unit #(
  parameter int REG_SIZE     = 5,
  parameter int CNT_SIZE     = 32,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  hazard_detection_unit_if.slave   bus
);

  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALTED} state_t;

  state_t        state_reg, state_next;
  logic [DW-1:0] drain_cnt_reg;
  logic          halted_reg;

  // Source operands of the ID instruction; index 0 = rs, 1 = rt.
  logic [REG_SIZE-1:0] src_addr [2];
  logic [1:0]          src_valid;
  logic [1:0]          ex_hit;
  logic [1:0]          mem_hit;

  assign src_addr[0]  = bus.i_ID_rs;
  assign src_addr[1]  = bus.i_ID_rt;
  // rt is only a real source for R-type, stores and branches.
  assign src_valid[0] = 1'b1;
  assign src_valid[1] = bus.i_ID_uses_rt | bus.i_ID_branch;

  // Register 0 is hardwired, so a zero address never matches.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      assign ex_hit[gi]  = src_valid[gi] && (src_addr[gi] != '0) &&
                           (src_addr[gi] == bus.i_EX_rd);
      assign mem_hit[gi] = src_valid[gi] && (src_addr[gi] != '0) &&
                           (src_addr[gi] == bus.i_MEM_rd);
    end
  endgenerate

  logic lu_hazard, br_ex_hazard, br_mem_hazard, hazard;

  assign lu_hazard     = bus.i_EX_mem_read && (|ex_hit);
  assign br_ex_hazard  = bus.i_ID_branch && bus.i_EX_write_reg && (|ex_hit);
  assign br_mem_hazard = bus.i_ID_branch && bus.i_MEM_mem_read && (|mem_hit);
  assign hazard        = lu_hazard | br_ex_hazard | br_mem_hazard;

  logic pc_write, if_id_write, id_ex_bubble, if_id_flush, stall_active;

  // Next-state and pipeline controls; stall outranks flush, flush outranks halt.
  always_comb begin
    state_next   = state_reg;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;
    stall_active = 1'b0;
    if (!bus.i_enable) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
    end else begin
      case (state_reg)
        ST_RUN: begin
          if (hazard) begin
            stall_active = 1'b1;
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
          end else if (bus.i_branch_taken) begin
            if_id_flush = 1'b1;
          end else if (bus.i_ID_halt) begin
            state_next = ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
          if (drain_cnt_reg == DRAIN_LAST) state_next = ST_HALTED;
        end
        default: begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
        end
      endcase
    end
  end

  // State, drain counter and sticky halted flag; all hold while disabled.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_reg     <= ST_RUN;
      drain_cnt_reg <= '0;
      halted_reg    <= 1'b0;
    end else if (bus.i_enable) begin
      state_reg <= state_next;
      if (state_reg == ST_RUN)        drain_cnt_reg <= '0;
      else if (state_reg == ST_DRAIN) drain_cnt_reg <= drain_cnt_reg + DW'(1);
      if (state_next == ST_HALTED)    halted_reg    <= 1'b1;
    end
  end

  // Saturating event counters: 0 = stall cycles, 1 = IF/ID flushes.
  logic [1:0] cnt_inc;
  assign cnt_inc[0] = stall_active;
  assign cnt_inc[1] = if_id_flush;

  generate
    for (gi = 0; gi < 2; gi++) begin : g_cnt
      logic [CNT_SIZE-1:0] count_reg;
      // Count the event unless already pinned at all-ones.
      always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
          count_reg <= '0;
        else if (cnt_inc[gi] && (count_reg != '1))
          count_reg <= count_reg + CNT_SIZE'(1);
      end
    end
  endgenerate

  assign bus.o_pc_write     = pc_write;
  assign bus.o_IF_ID_write  = if_id_write;
  assign bus.o_ID_EX_bubble = id_ex_bubble;
  assign bus.o_IF_ID_flush  = if_id_flush;
  assign bus.o_halted       = halted_reg;
  assign bus.o_stall_count  = g_cnt[0].count_reg;
  assign bus.o_flush_count  = g_cnt[1].count_reg;

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Directed-vector bench for hazard_detection_unit: hazards, flush, HALT
// drain timing, enable freeze and asynchronous reset.
module tb_hazard_detection_unit;

  localparam int REG_SIZE     = 5;
  localparam int CNT_SIZE     = 32;
  localparam int DRAIN_CYCLES = 4;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  hazard_detection_unit_if #(.REG_SIZE(REG_SIZE), .CNT_SIZE(CNT_SIZE)) hif ();

  hazard_detection_unit #(
    .REG_SIZE(REG_SIZE), .CNT_SIZE(CNT_SIZE), .DRAIN_CYCLES(DRAIN_CYCLES)
  ) dut (
    .i_clk  (clk),
    .i_reset(rst),
    .bus    (hif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: got=%0h", tag, got);
    end
  endtask

  // pc_write, IF_ID_write, bubble, flush in one go.
  task automatic check_ctrl(input string tag, input logic pc, input logic ifid,
                            input logic bub, input logic fl);
    check({tag, ".pc_write"},    32'(hif.o_pc_write),     32'(pc));
    check({tag, ".IF_ID_write"}, 32'(hif.o_IF_ID_write),  32'(ifid));
    check({tag, ".bubble"},      32'(hif.o_ID_EX_bubble), 32'(bub));
    check({tag, ".flush"},       32'(hif.o_IF_ID_flush),  32'(fl));
  endtask

  task automatic idle();
    hif.i_enable       = 1'b1;
    hif.i_ID_rs        = '0;
    hif.i_ID_rt        = '0;
    hif.i_ID_uses_rt   = 1'b0;
    hif.i_ID_branch    = 1'b0;
    hif.i_ID_halt      = 1'b0;
    hif.i_branch_taken = 1'b0;
    hif.i_EX_rd        = '0;
    hif.i_EX_mem_read  = 1'b0;
    hif.i_EX_write_reg = 1'b0;
    hif.i_MEM_rd       = '0;
    hif.i_MEM_mem_read = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Async reset pulse between clock edges, leaves bench 1ns after a posedge.
  task automatic pulse_reset();
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    tick();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    idle();

    // Reset state
    #2;
    check_ctrl("reset", 1'b1, 1'b1, 1'b0, 1'b0);
    check("reset.halted", 32'(hif.o_halted), 32'd0);
    check("reset.stall_cnt", hif.o_stall_count, 32'd0);
    check("reset.flush_cnt", hif.o_flush_count, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Load-use: LW $2 in EX, ADD rs=2 in ID
    hif.i_EX_rd = 5'd2; hif.i_EX_mem_read = 1'b1; hif.i_EX_write_reg = 1'b1;
    hif.i_ID_rs = 5'd2; hif.i_ID_rt = 5'd7; hif.i_ID_uses_rt = 1'b1;
    settle();
    check_ctrl("lu_rs", 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    check("lu.stall_cnt", hif.o_stall_count, 32'd1);
    // Load now in MEM, EX holds the bubble: ADD proceeds
    hif.i_EX_rd = '0; hif.i_EX_mem_read = 1'b0; hif.i_EX_write_reg = 1'b0;
    hif.i_MEM_rd = 5'd2; hif.i_MEM_mem_read = 1'b1;
    settle();
    check_ctrl("lu_after", 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    idle();

    // rt not a source (uses_rt=0, no branch): no load-use
    hif.i_EX_rd = 5'd5; hif.i_EX_mem_read = 1'b1; hif.i_ID_rt = 5'd5; hif.i_ID_rs = 5'd1;
    settle();
    check("lu_rt_unused.bubble", 32'(hif.o_ID_EX_bubble), 32'd0);
    // Same but rt is used: stall
    hif.i_ID_uses_rt = 1'b1;
    settle();
    check("lu_rt_used.bubble", 32'(hif.o_ID_EX_bubble), 32'd1);
    tick();
    check("lu_rt.stall_cnt", hif.o_stall_count, 32'd2);
    idle();
    // $0 never hazards
    hif.i_EX_rd = '0; hif.i_EX_mem_read = 1'b1; hif.i_ID_rs = '0; hif.i_ID_uses_rt = 1'b1;
    settle();
    check("lu_r0.pc_write", 32'(hif.o_pc_write), 32'd1);
    tick();
    idle();

    // LW $3 then BEQ $3,$0: two stalls
    hif.i_ID_branch = 1'b1; hif.i_ID_rs = 5'd3; hif.i_ID_rt = '0;
    hif.i_EX_rd = 5'd3; hif.i_EX_mem_read = 1'b1; hif.i_EX_write_reg = 1'b1;
    settle();
    check_ctrl("beq_ex", 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    hif.i_EX_rd = '0; hif.i_EX_mem_read = 1'b0; hif.i_EX_write_reg = 1'b0;
    hif.i_MEM_rd = 5'd3; hif.i_MEM_mem_read = 1'b1;
    settle();
    check_ctrl("beq_mem", 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    check("beq.stall_cnt", hif.o_stall_count, 32'd4);
    hif.i_MEM_rd = '0; hif.i_MEM_mem_read = 1'b0;
    settle();
    check("beq_clear.bubble", 32'(hif.o_ID_EX_bubble), 32'd0);
    // Same branch with EX_rd=0: no stall
    hif.i_EX_rd = '0; hif.i_EX_mem_read = 1'b1; hif.i_EX_write_reg = 1'b1;
    settle();
    check("beq_rd0.pc_write", 32'(hif.o_pc_write), 32'd1);
    // BR_EX from an ALU producer (not a load) on rt
    hif.i_EX_rd = 5'd9; hif.i_EX_mem_read = 1'b0; hif.i_ID_rt = 5'd9;
    settle();
    check("br_ex_alu.bubble", 32'(hif.o_ID_EX_bubble), 32'd1);
    tick();
    check("br_ex.stall_cnt", hif.o_stall_count, 32'd5);
    idle();

    // Taken branch, no hazard: one-cycle flush
    hif.i_ID_branch = 1'b1; hif.i_ID_rs = 5'd4; hif.i_branch_taken = 1'b1;
    settle();
    check_ctrl("flush", 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    hif.i_branch_taken = 1'b0; hif.i_ID_branch = 1'b0;
    settle();
    check("flush_next.flush", 32'(hif.o_IF_ID_flush), 32'd0);
    check("flush.flush_cnt", hif.o_flush_count, 32'd1);
    // Taken with load-use active: stall wins, no flush
    hif.i_ID_branch = 1'b1; hif.i_branch_taken = 1'b1;
    hif.i_EX_rd = 5'd4; hif.i_EX_mem_read = 1'b1;
    settle();
    check_ctrl("flush_lu", 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    check("flush_lu.flush_cnt", hif.o_flush_count, 32'd1);
    check("flush_lu.stall_cnt", hif.o_stall_count, 32'd6);
    idle();
    // Taken + HALT together: flush wins, stays in RUN
    hif.i_branch_taken = 1'b1; hif.i_ID_halt = 1'b1;
    settle();
    check("taken_halt.flush", 32'(hif.o_IF_ID_flush), 32'd1);
    tick();
    idle();
    settle();
    check_ctrl("taken_halt_next", 1'b1, 1'b1, 1'b0, 1'b0);
    check("taken_halt.flush_cnt", hif.o_flush_count, 32'd2);

    // Disabled with a hazard present: everything frozen, no bubble
    hif.i_enable = 1'b0; hif.i_EX_rd = 5'd6; hif.i_EX_mem_read = 1'b1; hif.i_ID_rs = 5'd6;
    settle();
    check_ctrl("disabled", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check("disabled.stall_cnt", hif.o_stall_count, 32'd6);
    idle();

    // HALT, then async reset mid-drain
    hif.i_ID_halt = 1'b1;
    settle();
    check("halt_cycle.pc_write", 32'(hif.o_pc_write), 32'd1);
    tick();
    hif.i_ID_halt = 1'b0;
    tick();
    check_ctrl("mid_drain", 1'b0, 1'b0, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("async_rst.pc_write", 32'(hif.o_pc_write), 32'd1);
    check("async_rst.halted", 32'(hif.o_halted), 32'd0);
    check("async_rst.stall_cnt", hif.o_stall_count, 32'd0);
    check("async_rst.flush_cnt", hif.o_flush_count, 32'd0);
    #2 rst = 1'b0;
    tick();

    // Full drain: halted rises exactly 4 edges after DRAIN entry
    hif.i_ID_halt = 1'b1;
    tick();                       // enter DRAIN
    idle();
    // Hazard and taken branch during DRAIN: no stall, no flush
    hif.i_ID_branch = 1'b1; hif.i_ID_rs = 5'd8; hif.i_branch_taken = 1'b1;
    hif.i_EX_rd = 5'd8; hif.i_EX_mem_read = 1'b1;
    settle();
    check_ctrl("drain", 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    tick();
    tick();
    check("drain3.halted", 32'(hif.o_halted), 32'd0);
    tick();
    check("drain4.halted", 32'(hif.o_halted), 32'd1);
    check("drain.stall_cnt", hif.o_stall_count, 32'd0);
    check("drain.flush_cnt", hif.o_flush_count, 32'd0);
    idle();
    hif.i_ID_halt = 1'b1; hif.i_branch_taken = 1'b1;
    tick();
    hif.i_enable = 1'b0;
    tick();
    check("halted_sticky.halted", 32'(hif.o_halted), 32'd1);
    hif.i_enable = 1'b1;
    settle();
    check_ctrl("halted", 1'b0, 1'b0, 1'b1, 1'b0);
    idle();

    // Enable low 3 cycles in DRAIN delays halting by 3
    pulse_reset();
    hif.i_ID_halt = 1'b1;
    tick();                       // enter DRAIN
    hif.i_ID_halt = 1'b0;
    tick();
    hif.i_enable = 1'b0;
    tick();
    tick();
    tick();
    check_ctrl("drain_frozen", 1'b0, 1'b0, 1'b0, 1'b0);
    hif.i_enable = 1'b1;
    tick();
    tick();
    check("freeze6.halted", 32'(hif.o_halted), 32'd0);
    tick();
    check("freeze7.halted", 32'(hif.o_halted), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
